// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN (adds ready timeout and FAULT state).
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    HOLD       = 3'd1,
    WAIT_READY = 3'd2,
    GAP        = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } seq_state_e;

  // Wide enough to index up to 8 sequenced stages.
  localparam int STAGE_IDX_W = 3;

  // Width of the shared counter; the timeout only widens it when the feature is built in.
  function automatic int cnt_width(input int hold, input int gap, input int timeout,
                                   input bit use_timeout);
    int m;
    m = (hold > gap) ? hold : gap;
    if (use_timeout && (timeout > m)) begin
      m = timeout;
    end else begin
      m = m;
    end
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchroniser, each bit independent, asynchronously cleared to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Next values: first stage captures the async input, second stage re-times it.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of per-domain active-low resets after PLL lock, with soft reset.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN -- when defined, a stage that does not
// report ready within READY_TIMEOUT cycles is put back in reset and fault_o is raised.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES      = 3,
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGE_GAP     = 8,
  parameter int READY_TIMEOUT = 1023
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                lock_i,
  input  logic [N_STAGES-1:0] stage_ready_i,
  input  logic                soft_rst_req_i,
  output logic [N_STAGES-1:0] stage_rst_n_o,
  output logic                all_ready_o,
  output logic                soft_rst_ack_o,
  output logic                fault_o
);

  localparam bit TIMEOUT_EN =
`ifdef RESET_SEQ_TIMEOUT_EN
    1'b1;
`else
    1'b0;
`endif

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, READY_TIMEOUT, TIMEOUT_EN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(READY_TIMEOUT - 1);
`endif
  localparam logic [STAGE_IDX_W-1:0] LAST_STAGE = STAGE_IDX_W'(N_STAGES - 1);
  localparam logic [STAGE_IDX_W-1:0] STAGE_ONE  = STAGE_IDX_W'(1);

  logic                   lock_s;
  logic [N_STAGES-1:0]    ready_s;
  logic [N_STAGES-1:0]    cur_sel;
  logic [N_STAGES-1:0]    next_sel;
  logic                   ready_cur;

  seq_state_e             state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [STAGE_IDX_W-1:0] k_d, k_q;
  logic [N_STAGES-1:0]    stage_rst_n_d, stage_rst_n_q;
  logic                   all_ready_d, all_ready_q;
  logic                   ack_d, ack_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (lock_i),
    .q_o       (lock_s)
  );

  sync_2ff #(.WIDTH(N_STAGES)) u_ready_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (stage_ready_i),
    .q_o       (ready_s)
  );

  // One-hot selects avoid indexing a vector with a wider stage index.
  assign cur_sel   = N_STAGES'(1'b1) << k_q;
  assign next_sel  = N_STAGES'(1'b1) << k_d;
  assign ready_cur = |(ready_s & cur_sel);

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      k_q           <= '0;
      stage_rst_n_q <= '0;
      all_ready_q   <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      stage_rst_n_q <= stage_rst_n_d;
      all_ready_q   <= all_ready_d;
      ack_q         <= ack_d;
    end
  end

  // Next-state logic; lock loss overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    if ((state_q != WAIT_LOCK) && !lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT_READY;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        WAIT_READY: begin
          if (ready_cur) begin
            if (k_q == LAST_STAGE) begin
              state_d = RUN;
            end else begin
              state_d = GAP;
              cnt_d   = '0;
            end
`ifdef RESET_SEQ_TIMEOUT_EN
          end else if (cnt_q == TO_LAST) begin
            state_d = FAULT;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
`else
          end else begin
            cnt_d   = cnt_q;
          end
`endif
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = WAIT_READY;
            cnt_d   = '0;
            k_d     = k_q + STAGE_ONE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (soft_rst_req_i) begin
            state_d = HOLD;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            state_d = RUN;
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        FAULT: begin
          if (soft_rst_req_i) begin
            state_d = HOLD;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            state_d = FAULT;
          end
        end
`endif
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          k_d     = '0;
        end
      endcase
    end
  end

  // Output next values derived from the transition being taken.
  always_comb begin
    all_ready_d = (state_d == RUN);
    ack_d       = ((state_q == RUN) || (state_q == FAULT)) && (state_d == HOLD);
    if ((state_d == WAIT_LOCK) || (state_d == HOLD)) begin
      stage_rst_n_d = '0;
    end else if ((state_d == WAIT_READY) && (state_q != WAIT_READY)) begin
      stage_rst_n_d = stage_rst_n_q | next_sel;
    end else if ((state_d == FAULT) && (state_q != FAULT)) begin
      stage_rst_n_d = stage_rst_n_q & ~cur_sel;
    end else begin
      stage_rst_n_d = stage_rst_n_q;
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  logic fault_d, fault_q;

  // Sticky fault: set on entry to FAULT, cleared by any exit from it.
  always_comb begin
    fault_d = (state_d == FAULT);
  end

  // Fault flag register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  assign stage_rst_n_o  = stage_rst_n_q;
  assign all_ready_o    = all_ready_q;
  assign soft_rst_ack_o = ack_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumes the PLL lock and per-domain ready indications. Drives ordered, stretched, active-low resets to N downstream clock/IP domains, for example fabric logic, then the DDR controller, then the user AXI fabric. Each stage is released only after the previous stage reports ready. Also services synchronous soft-reset requests from the management logic and reports sequencing timeouts.

Parameters:
N_STAGES, 3, number of sequenced reset outputs (1..8)
HOLD_CYCLES, 16, minimum cycles all resets stay asserted after lock is seen (>=1)
STAGE_GAP, 8, cycles between stage k ready and stage k+1 release (>=1)
READY_TIMEOUT, 1023, max cycles to wait for stage ready before fault (>=1)

Ports:
clk_i  in  1  free-running system clock
reset_n_i  in  1  asynchronous, active-low reset
lock_i  in  1  PLL lock, asynchronous to clk_i
stage_ready_i  in  N_STAGES  per-stage ready/calibration-done, asynchronous
soft_rst_req_i  in  1  synchronous single-cycle soft reset request
stage_rst_n_o  out  N_STAGES  registered active-low stage resets
all_ready_o  out  1  all stages released and ready
soft_rst_ack_o  out  1  one-cycle acknowledge of an accepted soft request
fault_o  out  1  sticky ready-timeout flag

Behaviour:
- Reset: clk_i is the clock; reset_n_i is asynchronous and active-low. While reset_n_i=0: stage_rst_n_o=0, all_ready_o=0, soft_rst_ack_o=0, fault_o=0, state=WAIT_LOCK, counters=0.
- Synchronisers: lock_i and each stage_ready_i bit pass through a 2-flop synchroniser.
  - Call the edge that samples the async input edge 0.
  - The synchronised value is visible to the FSM after edge 1 and acted on at edge 2.
- All outputs are registered; the FSM uses a single shared counter of width $clog2(max(HOLD_CYCLES,STAGE_GAP,READY_TIMEOUT)+1).
- WAIT_LOCK:
  - All stages held in reset.
  - On lock_s=1, go to HOLD with cnt=0.
- HOLD:
  - Count HOLD_CYCLES cycles.
  - On the last one, go to WAIT_READY with k=0 and stage_rst_n_o[0]<=1.
  - stage_rst_n_o[0] therefore rises at edge 2+HOLD_CYCLES.
- WAIT_READY(k):
  - On ready_s[k]=1: if k=N_STAGES-1, go to RUN with all_ready_o<=1; else go to GAP with cnt=0.
  - Timeout handling is per the optional feature.
- GAP:
  - Count STAGE_GAP cycles.
  - Then set k<=k+1, stage_rst_n_o[k+1]<=1, go to WAIT_READY.
- RUN:
  - Holding state.
  - A drop of stage_ready_i is ignored in RUN.
- Lock loss: lock_s=0 in any state except WAIT_LOCK forces, on the same edge, all stage_rst_n_o<=0, all_ready_o<=0, fault_o<=0, then WAIT_LOCK.
  - Lock loss has priority over everything else.
- Soft reset:
  - Accepted only in RUN or FAULT.
  - On the edge sampling soft_rst_req_i=1: soft_rst_ack_o<=1 for one cycle, all stage_rst_n_o<=0, all_ready_o<=0, fault_o<=0, go to HOLD with cnt=0.
  - In any other state the request is dropped with no ack.
  - A request coincident with lock loss is dropped; lock loss wins.
- Release order is strictly ascending k; a higher stage is never deasserted before a lower one.
- reset_n_i asserted mid-sequence clears everything asynchronously; sequencing restarts from WAIT_LOCK.

Optional Feature:
RESET_SEQ_TIMEOUT_EN
- Defined:
  - Stage k is in WAIT_READY and READY_TIMEOUT cycles elapse without ready_s[k]. The FSM then enters FAULT with fault_o<=1 and stage_rst_n_o[k]<=0.
  - Stages 0..k-1 stay released.
  - FAULT is exited only by soft reset, lock loss or reset_n_i.
- Undefined:
  - WAIT_READY waits indefinitely and the FAULT state is absent.
  - fault_o is tied 0 and the counter width ignores READY_TIMEOUT.

Decomposition:
- Package reset_seq_pkg: state enum (WAIT_LOCK, HOLD, WAIT_READY, GAP, RUN, FAULT); function for counter width; stage index width constant.
- One sub-module: sync_2ff, a parameterised-width bit synchroniser with asynchronous active-low reset to 0, instantiated for lock_i and stage_ready_i.

Test Plan (N_STAGES=3, HOLD_CYCLES=16, STAGE_GAP=8, READY_TIMEOUT=1023):
- Power-up: reset_n_i low 5 cycles, then lock_i=1 sampled at edge 0. Each ready is driven 4 cycles after its reset release. Expected:
  - stage_rst_n_o[0] rises at edge 18.
  - stage 1 releases at edge 18+4+2+8=32; stage 2 at edge 46.
  - all_ready_o=1 at edge 52.
- Lock loss: in RUN drop lock_i at edge 0 -> all stage_rst_n_o=0 and all_ready_o=0 at edge 2. Re-lock repeats the sequence.
- Soft reset: in RUN pulse soft_rst_req_i for 1 cycle -> soft_rst_ack_o=1 for exactly one cycle, all resets asserted on the same edge. stage 0 is released 16 cycles later.
- Ignored request: soft_rst_req_i pulsed during GAP -> no ack, and sequence timing is unchanged.
- Timeout (macro defined): stage_ready_i[1] held 0 -> 1023 cycles after stage 1 release:
  - fault_o=1 and stage_rst_n_o=3'b001.
  - A subsequent soft request clears fault_o and acks.
- Async reset: reset_n_i pulsed low mid-WAIT_READY -> all outputs 0 immediately, before the next clock edge; restart from WAIT_LOCK.
